// File: rtl/custom_fifo_pkg.sv
// rtl/custom_fifo_pkg.sv - shared types and constants for the FIFO read-side packer
package custom_fifo_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } rdpk_state_t;

   localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/custom_rdpk_idle_timer.sv
// rtl/custom_rdpk_idle_timer.sv - saturating idle counter for the read packer
// Counts every cycle it is not cleared and sticks at TIMEOUT-1, flagging expiry there.
module custom_rdpk_idle_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   output logic o_expired
);

   localparam int                IDLE_W = $clog2(TIMEOUT);
   localparam logic [IDLE_W-1:0] LAST   = IDLE_W'(TIMEOUT - 1);

   logic [IDLE_W-1:0] r_idle_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idle_cnt <= '0;
      end else if (i_clr) begin
         r_idle_cnt <= '0;
      end else if (r_idle_cnt != LAST) begin
         r_idle_cnt <= r_idle_cnt + 1'b1;
      end
   end

   assign o_expired = (r_idle_cnt == LAST);

endmodule

// File: rtl/custom_fifo_rd_packer.sv
// rtl/custom_fifo_rd_packer.sv - packs RATIO show-ahead FIFO words into one keep-masked beat
// Lane 0 holds the oldest word; partial beats leave on idle timeout or flush.
module custom_fifo_rd_packer
   import custom_fifo_pkg::*;
#(
   parameter int DATASIZE = 8,
   parameter int RATIO    = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic                      rclk_i,
   input  logic                      rrst_i,
   input  logic                      fifo_empty,
   input  logic [DATASIZE-1:0]       dout,
   output logic                      ren,
   input  logic                      flush_i,
   output logic [DATASIZE*RATIO-1:0] m_data,
   output logic [RATIO-1:0]          m_keep,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [BEAT_CNT_W-1:0]     beat_cnt_o
);

   localparam int                LANE_W    = $clog2(RATIO);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

   rdpk_state_t               r_state;
   rdpk_state_t               w_state_nxt;
   logic [LANE_W-1:0]         r_lane_cnt;
   logic [DATASIZE*RATIO-1:0] r_data;
   logic [RATIO-1:0]          r_keep;
   logic                      r_valid;
   logic [BEAT_CNT_W-1:0]     r_beat_cnt;

   logic w_pop;
   logic w_handshake;
   logic w_emit;
   logic w_timeout;
   logic w_idle_clr;

   assign w_handshake = r_valid && m_ready;

   // A popped word joins the beat before any flush; without a pop, only a non-empty beat can leave.
   assign w_emit = (r_state == FILL) &&
                   (w_pop ? ((r_lane_cnt == LAST_LANE) || flush_i)
                          : ((r_lane_cnt != '0) && (flush_i || w_timeout)));

   assign w_idle_clr = (r_state == HOLD) || w_pop || (r_lane_cnt == '0);

   custom_rdpk_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .i_clk     (rclk_i),
      .i_rst     (rrst_i),
      .i_clr     (w_idle_clr),
      .o_expired (w_timeout)
   );

   always_ff @(posedge rclk_i or posedge rrst_i) begin
      if (rrst_i) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FILL: if (w_emit)      w_state_nxt = HOLD;
         HOLD: if (w_handshake) w_state_nxt = FILL;
         default:               w_state_nxt = FILL;
      endcase
   end

   // Popping in HOLD is only safe when the held beat leaves this same cycle.
   always_comb begin
      w_pop = 1'b0;
      if (!rrst_i && !fifo_empty) begin
         if (r_state == FILL) begin
            w_pop = 1'b1;
         end else begin
            w_pop = m_ready;
         end
      end
   end

   assign ren = w_pop;

   always_ff @(posedge rclk_i or posedge rrst_i) begin
      if (rrst_i) begin
         r_lane_cnt <= '0;
         r_data     <= '0;
         r_keep     <= '0;
         r_valid    <= 1'b0;
         r_beat_cnt <= '0;
      end else if (r_state == FILL) begin
         if (w_pop) begin
            for (int i = 0; i < RATIO; i++) begin
               if (r_lane_cnt == LANE_W'(i)) begin
                  r_data[i*DATASIZE +: DATASIZE] <= dout;
                  r_keep[i]                      <= 1'b1;
               end
            end
            r_lane_cnt <= w_emit ? '0 : r_lane_cnt + 1'b1;
         end else if (w_emit) begin
            r_lane_cnt <= '0;
         end
         r_valid <= w_emit;
      end else if (w_handshake) begin
         r_beat_cnt <= r_beat_cnt + 1'b1;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_keep     <= '0;
         if (w_pop) begin
            r_data[DATASIZE-1:0] <= dout;
            r_keep[0]            <= 1'b1;
            r_lane_cnt           <= LANE_W'(1);
         end
      end
   end

   assign m_data     = r_data;
   assign m_keep     = r_keep;
   assign m_valid    = r_valid;
   assign beat_cnt_o = r_beat_cnt;

endmodule

// File: tb/tb_custom_fifo_rd_packer.sv
// tb/tb_custom_fifo_rd_packer.sv - directed table-driven bench for custom_fifo_rd_packer
module tb_custom_fifo_rd_packer;

   localparam int DATASIZE = 8;
   localparam int RATIO    = 4;
   localparam int TIMEOUT  = 16;

   logic        rclk_i  = 1'b0;
   logic        rrst_i  = 1'b1;
   logic        flush_i = 1'b0;
   logic        m_ready = 1'b0;
   logic        fifo_empty;
   logic        ren;
   logic        m_valid;
   logic [7:0]  dout;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic [15:0] beat_cnt_o;

   logic [7:0]  mem [0:4095];
   int          wp = 0;
   int          rp = 0;
   int          total = 0;
   int          bad = 0;
   int          exp_beats = 0;
   bit          underflow = 1'b0;
   bit          cap_en = 1'b0;
   int          cap_n = 0;
   logic [31:0] cap_data [0:255];

   typedef struct {
      int          n;
      logic [31:0] words;
      bit          flush;
      logic [31:0] exp_data;
      logic [3:0]  exp_keep;
   } vec_t;

   vec_t vecs [0:5];

   assign fifo_empty = (wp == rp);
   assign dout       = mem[rp[11:0]];

   always #5 rclk_i = ~rclk_i;

   custom_fifo_rd_packer #(
      .DATASIZE (DATASIZE),
      .RATIO    (RATIO),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .rclk_i     (rclk_i),
      .rrst_i     (rrst_i),
      .fifo_empty (fifo_empty),
      .dout       (dout),
      .ren        (ren),
      .flush_i    (flush_i),
      .m_data     (m_data),
      .m_keep     (m_keep),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .beat_cnt_o (beat_cnt_o)
   );

   // FIFO read side and beat capture
   always @(posedge rclk_i) begin
      if (ren && fifo_empty) underflow <= 1'b1;
      if (ren && !fifo_empty) rp <= rp + 1;
      if (cap_en && m_valid && m_ready && cap_n < 256) begin
         cap_data[cap_n] <= m_data;
         cap_n           <= cap_n + 1;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge rclk_i);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wp[11:0]] = b;
      wp++;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (!m_valid && n < budget) begin
         tick();
         n++;
      end
      check({name, "_valid"}, 32'(m_valid), 32'h1);
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (wp != rp && n < budget) begin
         tick();
         n++;
      end
      check("fifo_drained", 32'(wp - rp), 32'h0);
   endtask

   task automatic release_beat(input string name);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      exp_beats++;
      check({name, "_beat_cnt"}, 32'(beat_cnt_o), 32'(exp_beats));
      check({name, "_valid_drop"}, 32'(m_valid), 32'h0);
   endtask

   initial begin
      int          cycles;
      int          mism;
      logic [7:0]  b;
      logic [31:0] exp_word;

      vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF};
      vecs[1] = '{2, 32'h00000201, 1'b1, 32'h00000201, 4'h3};
      vecs[2] = '{1, 32'h000000A5, 1'b0, 32'h000000A5, 4'h1};
      vecs[3] = '{3, 32'h00BEADDE, 1'b1, 32'h00BEADDE, 4'h7};
      vecs[4] = '{4, 32'hC3B2A190, 1'b1, 32'hC3B2A190, 4'hF};
      vecs[5] = '{3, 32'h00302010, 1'b0, 32'h00302010, 4'h7};

      tick(2);
      check("rst_valid", 32'(m_valid), 32'h0);
      check("rst_keep",  32'(m_keep), 32'h0);
      check("rst_data",  m_data, 32'h0);
      check("rst_beat",  32'(beat_cnt_o), 32'h0);
      check("rst_ren",   32'(ren), 32'h0);
      rrst_i = 1'b0;
      tick();

      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < vecs[v].n; k++) push(vecs[v].words[8*k +: 8]);
         wait_empty(10);
         if (vecs[v].flush) begin
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
            check($sformatf("vec%0d_flush_valid", v), 32'(m_valid), 32'h1);
         end else begin
            wait_valid($sformatf("vec%0d", v), TIMEOUT + 8);
         end
         check($sformatf("vec%0d_data", v), m_data, vecs[v].exp_data);
         check($sformatf("vec%0d_keep", v), 32'(m_keep), 32'(vecs[v].exp_keep));
         release_beat($sformatf("vec%0d", v));
         check($sformatf("vec%0d_keep_clr", v), 32'(m_keep), 32'h0);
      end

      // Exact timeout: emit after the 16th idle cycle, not before
      push(8'hA5);
      tick(16);
      check("to_early_valid", 32'(m_valid), 32'h0);
      tick();
      check("to_valid", 32'(m_valid), 32'h1);
      check("to_data", m_data, 32'h000000A5);
      check("to_keep", 32'(m_keep), 32'h1);
      release_beat("to");

      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      tick(20);
      check("flush_empty_valid", 32'(m_valid), 32'h0);
      check("flush_empty_beat", 32'(beat_cnt_o), 32'(exp_beats));

      // Backpressure with words waiting in the FIFO
      for (int k = 1; k <= 8; k++) push(8'(k));
      wait_valid("bp", 10);
      check("bp_data0", m_data, 32'h04030201);
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp_ren", 32'(ren), 32'h0);
         check("bp_data", m_data, 32'h04030201);
      end
      m_ready = 1'b1;
      #1;
      check("bp_release_ren", 32'(ren), 32'h1);
      tick();
      m_ready = 1'b0;
      exp_beats++;
      check("bp_hs_valid", 32'(m_valid), 32'h0);
      check("bp_hs_keep", 32'(m_keep), 32'h1);
      check("bp_hs_data", m_data, 32'h00000005);
      check("bp_hs_beat", 32'(beat_cnt_o), 32'(exp_beats));
      wait_valid("bp2", 10);
      check("bp2_data", m_data, 32'h08070605);
      check("bp2_keep", 32'(m_keep), 32'hF);
      release_beat("bp2");

      // Reset while holding a beat; queued FIFO words survive
      for (int k = 0; k < 4; k++) push(8'(8'h61 + k));
      for (int k = 0; k < 4; k++) push(8'(8'h91 + k));
      wait_valid("mr", 10);
      check("mr_data_pre", m_data, 32'h64636261);
      rrst_i = 1'b1;
      #1;
      check("mr_valid", 32'(m_valid), 32'h0);
      check("mr_keep", 32'(m_keep), 32'h0);
      check("mr_beat", 32'(beat_cnt_o), 32'h0);
      check("mr_ren", 32'(ren), 32'h0);
      tick(2);
      rrst_i = 1'b0;
      exp_beats = 0;
      wait_valid("mr_post", 10);
      check("mr_post_data", m_data, 32'h94939291);
      check("mr_post_keep", 32'(m_keep), 32'hF);
      release_beat("mr_post");

      rrst_i = 1'b1;
      tick();
      rrst_i = 1'b0;
      exp_beats = 0;

      // Streaming: 1024 words at full rate
      for (int i = 0; i < 1024; i++) push(8'(i * 37 + 5));
      cap_en  = 1'b1;
      m_ready = 1'b1;
      cycles  = 0;
      while (cap_n < 256 && cycles < 3000) begin
         tick();
         cycles++;
      end
      m_ready = 1'b0;
      cap_en  = 1'b0;
      check("stream_beats", 32'(cap_n), 32'd256);
      check("stream_cycles", 32'(cycles), 32'd1025);
      check("stream_beat_cnt", 32'(beat_cnt_o), 32'd256);
      check("stream_underflow", 32'(underflow), 32'h0);
      mism = 0;
      for (int k = 0; k < cap_n; k++) begin
         for (int j = 0; j < 4; j++) begin
            b = 8'((4 * k + j) * 37 + 5);
            exp_word[8*j +: 8] = b;
         end
         if (cap_data[k] !== exp_word) mism++;
      end
      check("stream_order", 32'(mism), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
